// File: rtl/led_shift_pkg.sv
// led_shift_pkg: shared state type, default sizes and width helper for the LED shift-out block
package led_shift_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_e;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CLK_DIV = 4;
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/shift_tick.sv
// shift_tick: divider counting 0..CLK_DIV-1 with restart; tc_o marks the last cycle of a phase
module shift_tick
    import led_shift_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tc_o
);
    localparam int CW = clog2_min1(CLK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tc_o  = cnt_q == CW'(CLK_DIV - 1);
    assign cnt_d = (restart_i || tc_o) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_i) begin
        cnt_q <= rst_i ? '0 : cnt_d;
    end
endmodule

// File: rtl/led_shift_out.sv
// led_shift_out: shifts each accepted frame MSB-first into a 74HC595 chain, then pulses RCLK
module led_shift_out
    import led_shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             _i_clk,
    input  logic             _i_rst,
    input  logic [WIDTH-1:0] _i_data,
    input  logic             _i_valid,
    output logic             _o_ready,
    output logic             _o_ser,
    output logic             _o_srclk,
    output logic             _o_rclk,
    output logic             _o_busy
);
    localparam int IW = clog2_min1(WIDTH);
    state_e           state_q;
    logic [WIDTH-1:0] sr_q, sr_sh;
    logic [IW-1:0]    idx_q;
    logic             ser_q, srclk_q, rclk_q, tc;
    // Divider is held at zero while idle so every phase starts a full CLK_DIV count
    shift_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i    (_i_clk),
        .rst_i    (_i_rst),
        .restart_i(state_q == IDLE),
        .tc_o     (tc)
    );
    assign sr_sh = sr_q << 1;
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (_i_valid) begin
                    state_q <= SHIFT_LO;
                    sr_q    <= _i_data;
                    idx_q   <= IW'(WIDTH - 1);
                    ser_q   <= _i_data[WIDTH-1];
                end
                SHIFT_LO: if (tc) begin
                    state_q <= SHIFT_HI;
                    srclk_q <= 1'b1;
                end
                SHIFT_HI: if (tc) begin
                    sr_q    <= sr_sh;
                    srclk_q <= 1'b0;
                    if (idx_q == '0) begin
                        state_q <= LATCH;
                        rclk_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT_LO;
                        idx_q   <= idx_q - 1'b1;
                        ser_q   <= sr_sh[WIDTH-1];
                    end
                end
                default: if (tc) begin
                    state_q <= IDLE;
                    rclk_q  <= 1'b0;
                end
            endcase
        end
    end
    assign _o_ready = state_q == IDLE;
    assign _o_busy  = !_o_ready;
    assign _o_ser   = ser_q;
    assign _o_srclk = srclk_q;
    assign _o_rclk  = rclk_q;
endmodule

// File: tb/tb_led_shift_out.sv
// tb_led_shift_out: directed and random frames into CLK_DIV=4 and CLK_DIV=1 instances with a 595 chain model
module tb_led_shift_out;
    logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, sel = 1'b0;
    logic [7:0] data = 8'h00;
    logic       v4, v1, rdy4, ser4, sc4, rc4, busy4, rdy1, ser1, sc1, rc1, busy1;
    logic       rdy, ser, sc, rc, busy;
    logic [7:0] sh4 = 8'h00, st4 = 8'h00, sh1 = 8'h00, st1 = 8'h00, st;
    int         rises4 = 0, n_asrt = 0, n_fail = 0;

    always #5 clk = ~clk;

    assign v4 = valid & !sel;
    assign v1 = valid & sel;
    assign rdy  = sel ? rdy1 : rdy4;
    assign ser  = sel ? ser1 : ser4;
    assign sc   = sel ? sc1 : sc4;
    assign rc   = sel ? rc1 : rc4;
    assign busy = sel ? busy1 : busy4;
    assign st   = sel ? st1 : st4;

    led_shift_out #(.WIDTH(8), .CLK_DIV(4)) dut4 (
        ._i_clk(clk), ._i_rst(rst), ._i_data(data), ._i_valid(v4), ._o_ready(rdy4),
        ._o_ser(ser4), ._o_srclk(sc4), ._o_rclk(rc4), ._o_busy(busy4)
    );
    led_shift_out #(.WIDTH(8), .CLK_DIV(1)) dut1 (
        ._i_clk(clk), ._i_rst(rst), ._i_data(data), ._i_valid(v1), ._o_ready(rdy1),
        ._o_ser(ser1), ._o_srclk(sc1), ._o_rclk(rc1), ._o_busy(busy1)
    );

    // External 74HC595 chains: shift on SRCLK rise, copy to storage on RCLK rise
    always @(posedge sc4) begin
        sh4    <= {sh4[6:0], ser4};
        rises4 <= rises4 + 1;
    end
    always @(posedge rc4) st4 <= sh4;
    always @(posedge sc1) sh1 <= {sh1[6:0], ser1};
    always @(posedge rc1) st1 <= sh1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one frame on the selected instance; alt is driven on data and hold on valid while busy
    task automatic frame(input logic [7:0] d, input logic [7:0] alt, input logic hold);
        int div, n, rises, hi, rw, rr, bad;
        logic [7:0] bits;
        logic ps, pr, pser;
        div = sel ? 1 : 4;
        n = 0; rises = 0; hi = 0; rw = 0; rr = 0; bad = 0;
        bits = 8'h00; ps = 1'b0; pr = 1'b0; pser = 1'b0;
        data = d;
        valid = 1'b1;
        chk("ready_before_accept", rdy, 1);
        @(negedge clk);
        data = alt;
        valid = hold;
        while (!rdy && n < 200) begin
            n++;
            if (sc) hi++;
            if (sc && !ps) begin
                bits = {bits[6:0], ser};
                rises++;
            end
            if (sc && ps && ser !== pser) bad++;
            if (rc) rw++;
            if (rc && !pr) begin
                rr++;
                if (rises != 8 || sc) bad++;
            end
            ps = sc; pr = rc; pser = ser;
            @(negedge clk);
        end
        chk("busy_cycles", n, 17 * div);
        chk("srclk_rises", rises, 8);
        chk("srclk_high_cycles", hi, 8 * div);
        chk("bit_stream", bits, d);
        chk("rclk_width", rw, div);
        chk("rclk_pulses", rr, 1);
        chk("timing_rules", bad, 0);
        chk("latched_frame", st, d);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int n, r, r0, hits;
        logic p;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        chk("rst_ready4", rdy4, 1);
        chk("rst_outs4", {ser4, sc4, rc4, busy4}, 0);
        chk("rst_ready1", rdy1, 1);
        chk("rst_outs1", {ser1, sc1, rc1, busy1}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", rdy4, 1);

        frame(8'hA5, 8'hA5, 1'b0);

        r0 = rises4;
        frame(8'hFF, 8'h00, 1'b1);
        frame(8'h00, 8'h00, 1'b0);
        chk("b2b_total_rises", rises4 - r0, 16);

        frame(8'h81, 8'h3C, 1'b1);
        frame(8'h3C, 8'h3C, 1'b0);

        data = 8'hF0;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        n = 0; r = 0; p = 1'b0;
        while (r < 3 && n < 200) begin
            if (sc4 && !p) r++;
            p = sc4;
            n++;
            @(negedge clk);
        end
        chk("midframe_reached", r, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_srclk", sc4, 0);
        chk("abort_rclk", rc4, 0);
        chk("abort_ready", rdy4, 1);
        hits = 0;
        repeat (80) begin
            @(negedge clk);
            if (rc4 || sc4) hits++;
        end
        chk("abort_no_pulses", hits, 0);
        chk("abort_storage_kept", st4, 8'h3C);

        sel = 1'b1;
        frame(8'h01, 8'h01, 1'b0);

        rst = 1'b1;
        valid = 1'b1;
        data = 8'hA5;
        @(negedge clk);
        chk("rst_valid_ready", rdy1, 1);
        chk("rst_valid_outs", {ser1, sc1, rc1, busy1}, 0);
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("rst_valid_idle", {rdy1, sc1, rc1}, 3'b100);

        repeat (8) begin
            sel = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            frame(d, 8'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
